// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths and flag bundle
package alu_pkg;

    localparam int XOR_WIDTH = 32;

    function automatic int popcnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int POPCNT_W = popcnt_width(XOR_WIDTH);

    typedef struct packed {
        logic zero;
        logic parity;
    } alu_flags_t;

endpackage

// File: rtl/xor_bit_slice.sv
// rtl/xor_bit_slice.sv - single-bit XOR cell
module xor_bit_slice (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_32bit.sv
// rtl/xor_32bit.sv - registered bitwise XOR with zero/parity flags; XOR_POPCOUNT_EN adds popcnt
module xor_32bit
    import alu_pkg::*;
#(
    parameter int WIDTH = XOR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out,
    output logic                           zero,
    output logic                           parity
`ifdef XOR_POPCOUNT_EN
    ,
    output logic [popcnt_width(WIDTH)-1:0] popcnt
`endif
);

    localparam int PW = popcnt_width(WIDTH);

    logic [WIDTH-1:0] x_vec;
    alu_flags_t       flags_next;
    alu_flags_t       flags_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        xor_bit_slice u_slice (
            .a (a[i]),
            .b (b[i]),
            .y (x_vec[i])
        );
    end

    // Flags come from the fresh XOR vector so they line up with the value captured into out.
    always_comb begin
        flags_next        = '0;
        flags_next.zero   = ~|x_vec;
        flags_next.parity = ^x_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            flags_q   <= '{zero: 1'b1, parity: 1'b0};
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out     <= x_vec;
                flags_q <= flags_next;
            end
        end
    end

    assign zero   = flags_q.zero;
    assign parity = flags_q.parity;

`ifdef XOR_POPCOUNT_EN
    localparam int LVL    = $clog2(WIDTH);
    localparam int LEAVES = 1 << LVL;

    // Binary adder tree; leaves past WIDTH are padded with zero.
    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
        localparam int N = LEAVES >> l;
        logic [PW-1:0] sum [N];
        for (genvar j = 0; j < N; j++) begin : g_node
            if (l == 0) begin : g_leaf
                if (j < WIDTH) begin : g_bit
                    assign sum[j] = {{(PW-1){1'b0}}, x_vec[j]};
                end else begin : g_pad
                    assign sum[j] = '0;
                end
            end else begin : g_add
                assign sum[j] = g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            popcnt <= '0;
        end else if (in_valid) begin
            popcnt <= g_lvl[LVL].sum[0];
        end
    end
`endif

endmodule

// File: tb/tb_xor_32bit.sv
// tb/tb_xor_32bit.sv - directed and random checks for xor_32bit
module tb_xor_32bit;
    import alu_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic [31:0]         a;
    logic [31:0]         b;
    logic                out_valid;
    logic [31:0]         out;
    logic                zero;
    logic                parity;
`ifdef XOR_POPCOUNT_EN
    logic [POPCNT_W-1:0] popcnt;
`endif

    int checks = 0;
    int errors = 0;

    xor_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out       (out),
        .zero      (zero),
        .parity    (parity)
`ifdef XOR_POPCOUNT_EN
        ,
        .popcnt    (popcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [31:0] o,
                           input logic z, input logic p, input int pc);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
        chk({tag, ".out"}, out, o);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, z});
        chk({tag, ".parity"}, {31'b0, parity}, {31'b0, p});
`ifdef XOR_POPCOUNT_EN
        chk({tag, ".popcnt"}, 32'(popcnt), 32'(pc));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_out;
        logic        v;

        // Reset held with valid data presented
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 32'hFFFFFFFF;
        b        = 32'h12345678;
        tick();
        tick();
        chk_all("reset_hold", 1'b0, 32'h0, 1'b1, 1'b0, 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back directed vectors
        a = 32'hFFFFFFFF; b = 32'h12345678; in_valid = 1'b1;
        tick();
        chk_all("vec1", 1'b1, 32'hEDCBA987, 1'b0, 1'b1, 19);
        a = 32'h00000001; b = 32'hFFFFFFFF;
        tick();
        chk_all("vec2", 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 31);
        a = 32'h10000001; b = 32'h10000000;
        tick();
        chk_all("vec3", 1'b1, 32'h00000001, 1'b0, 1'b1, 1);
        a = 32'hA5A5A5A5; b = 32'hA5A5A5A5;
        tick();
        chk_all("equal", 1'b1, 32'h00000000, 1'b1, 1'b0, 0);

        // Hold with idle cycle and X operands
        a = 32'h0000FFFF; b = 32'h00000000;
        tick();
        chk_all("hold_load", 1'b1, 32'h0000FFFF, 1'b0, 1'b0, 16);
        in_valid = 1'b0; a = 32'hDEADBEEF; b = 'x;
        tick();
        chk_all("hold_idle", 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 16);
        tick();
        chk_all("hold_idle2", 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 16);

        // Asynchronous reset mid-cycle after valid data
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h12345678;
        tick();
        chk_all("pre_async", 1'b1, 32'hEDCBA987, 1'b0, 1'b1, 19);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 32'h0, 1'b1, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Random pairs with random valid gaps against a simple reference model
        exp_out = 32'h0;
        for (int i = 0; i < 1000; i++) begin
            v        = ($urandom_range(0, 3) != 0);
            in_valid = v;
            a        = $urandom;
            b        = $urandom;
            if (i % 97 == 0) b = a;
            if (v) exp_out = a ^ b;
            tick();
            chk_all("random", v, exp_out, (exp_out == 32'h0), ^exp_out, $countones(exp_out));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
